// File: rtl/isqrt_rr_sharer_if.sv
// Request/result bundle between N_REQ requesters, the sharer and one pipelined isqrt unit.
// slave = the sharer's view; master = the requester/isqrt side.
interface isqrt_rr_sharer_if #(
    parameter int N_REQ = 4,
    parameter int ARG_W = 32,
    parameter int RES_W = 16
);
    logic [N_REQ-1:0]       arg_vld;
    logic [N_REQ*ARG_W-1:0] arg;
    logic [N_REQ-1:0]       arg_rdy;
    logic                   x_vld;
    logic [ARG_W-1:0]       x;
    logic                   y_vld;
    logic [RES_W-1:0]       y;
    logic [N_REQ-1:0]       res_vld;
    logic [RES_W-1:0]       res;
    logic                   err;

    modport slave (
        input  arg_vld, arg, y_vld, y,
        output arg_rdy, x_vld, x, res_vld, res, err
    );

    modport master (
        output arg_vld, arg, y_vld, y,
        input  arg_rdy, x_vld, x, res_vld, res, err
    );
endinterface

// File: rtl/isqrt_rr_sharer.sv
// Round-robin sharing of one pipelined isqrt unit among N_REQ requesters; ISQRT_SHARER_STATS_EN adds grant counters.
// Latency: acceptance edge to res_vld is ISQRT_LAT+1 cycles, one request per cycle.
// Backpressure: arg_rdy grants at most one requester per cycle; the result path never stalls.
module isqrt_rr_sharer #(
    parameter int N_REQ     = 4,
    parameter int ARG_W     = 32,
    parameter int RES_W     = 16,
    parameter int ISQRT_LAT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    isqrt_rr_sharer_if.slave      bus
`ifdef ISQRT_SHARER_STATS_EN
    ,
    output logic [N_REQ*16-1:0]   grant_cnt
`endif
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [IDX_W:0]   N_REQ_V = (IDX_W+1)'(N_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

    logic [IDX_W-1:0] ptr;
    logic             gnt_any;
    logic [IDX_W-1:0] gnt_idx;
    logic [N_REQ-1:0] gnt_oh;
    logic [ARG_W-1:0] arg_a [N_REQ];
    logic [ARG_W-1:0] gnt_arg;

    logic [IDX_W-1:0] x_idx;
    logic [ISQRT_LAT-1:0] tag_vld;
    logic [IDX_W-1:0]     tag_idx [ISQRT_LAT];
    logic                 tag_out_vld;
    logic [IDX_W-1:0]     tag_out_idx;

    for (genvar i = 0; i < N_REQ; i++) begin : g_arg
        assign arg_a[i] = bus.arg[i*ARG_W +: ARG_W];
    end

    // Search ptr, ptr+1, ... with wrap; the first asserted valid wins.
    always_comb begin
        logic [IDX_W:0]   sum;
        logic [IDX_W-1:0] cand;
        gnt_any = 1'b0;
        gnt_idx = '0;
        sum     = '0;
        cand    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = {1'b0, ptr} + (IDX_W+1)'(k);
            if (sum >= N_REQ_V) begin
                sum = sum - N_REQ_V;
            end
            cand = sum[IDX_W-1:0];
            if (!gnt_any && bus.arg_vld[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
        if (rst) begin
            gnt_any = 1'b0;
        end
    end

    assign gnt_oh      = gnt_any ? (N_REQ'(1) << gnt_idx) : '0;
    assign gnt_arg     = arg_a[gnt_idx];
    assign bus.arg_rdy = gnt_oh;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            bus.x_vld <= 1'b0;
            bus.x     <= '0;
            x_idx     <= '0;
        end else if (gnt_any) begin
            ptr       <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
            bus.x_vld <= 1'b1;
            bus.x     <= gnt_arg;
            x_idx     <= gnt_idx;
        end else begin
            bus.x_vld <= 1'b0;
        end
    end

    // Tag pipe mirrors the isqrt latency so each y lines up with its requester index.
    for (genvar k = 0; k < ISQRT_LAT; k++) begin : g_tag
        if (k == 0) begin : g_head
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    tag_vld[0] <= 1'b0;
                    tag_idx[0] <= '0;
                end else begin
                    tag_vld[0] <= bus.x_vld;
                    tag_idx[0] <= x_idx;
                end
            end
        end else begin : g_body
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    tag_vld[k] <= 1'b0;
                    tag_idx[k] <= '0;
                end else begin
                    tag_vld[k] <= tag_vld[k-1];
                    tag_idx[k] <= tag_idx[k-1];
                end
            end
        end
    end

    assign tag_out_vld = tag_vld[ISQRT_LAT-1];
    assign tag_out_idx = tag_idx[ISQRT_LAT-1];

    assign bus.res_vld = (!rst && bus.y_vld && tag_out_vld) ? (N_REQ'(1) << tag_out_idx) : '0;
    assign bus.res     = bus.y;

    // A y_vld without a matching tag (or vice versa) means the unit and the sharer disagree.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.err <= 1'b0;
        end else if (bus.y_vld != tag_out_vld) begin
            bus.err <= 1'b1;
        end
    end

`ifdef ISQRT_SHARER_STATS_EN
    logic [15:0] cnt [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_cnt
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt[i] <= '0;
            end else if (gnt_oh[i]) begin
                cnt[i] <= cnt[i] + 16'd1;
            end
        end
        assign grant_cnt[i*16 +: 16] = cnt[i];
    end
`endif

endmodule

// File: tb/tb_isqrt_rr_sharer.sv
// Randomized bench for isqrt_rr_sharer with a behavioural isqrt stand-in and a queue-based scoreboard.
module tb_isqrt_rr_sharer;

    localparam int N   = 4;
    localparam int AW  = 32;
    localparam int RW  = 16;
    localparam int LAT = 4;

    logic clk = 1'b0;
    logic rst;
    logic inj;

    isqrt_rr_sharer_if #(.N_REQ(N), .ARG_W(AW), .RES_W(RW)) bus ();

`ifdef ISQRT_SHARER_STATS_EN
    logic [N*16-1:0] grant_cnt;
`endif

    isqrt_rr_sharer #(.N_REQ(N), .ARG_W(AW), .RES_W(RW), .ISQRT_LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus)
`ifdef ISQRT_SHARER_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] isqrt_f(input logic [31:0] a);
        longint r;
        longint t;
        r = 0;
        for (int b = 15; b >= 0; b--) begin
            t = r | (longint'(1) << b);
            if (t * t <= longint'({32'b0, a})) r = t;
        end
        return r[15:0];
    endfunction

    // Stand-in isqrt unit: fixed LAT-cycle pipe, reset with the sharer.
    logic [LAT-1:0] mv;
    logic [RW-1:0]  my [LAT];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mv <= '0;
            for (int k = 0; k < LAT; k++) my[k] <= '0;
        end else begin
            mv <= {mv[LAT-2:0], bus.x_vld};
            for (int k = LAT-1; k > 0; k--) my[k] <= my[k-1];
            my[0] <= isqrt_f(bus.x);
        end
    end
    assign bus.y_vld = mv[LAT-1] | inj;
    assign bus.y     = my[LAT-1];

    typedef struct {
        int          idx;
        logic [15:0] val;
        int          due;
    } exp_t;

    exp_t        q[$];
    int          mptr, cyc, total, bad;
    logic        exp_xv, merr;
    logic [31:0] exp_x;
    logic [31:0] cur_arg [N];
    int          mcnt [N];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    function automatic logic [31:0] rnd_arg();
        int unsigned r;
        r = $urandom_range(0, 65535);
        case ($urandom_range(0, 4))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return r * r;
            3: return r * r - 1;
            default: return $urandom;
        endcase
    endfunction

    // One clock: drive at negedge, check at negedge+1, then update the model.
    task automatic cycle(input logic [N-1:0] vld, input logic inj_i, output logic gv, output int gi);
        logic [N*AW-1:0] pk;
        logic [N-1:0]    exp_rdy;
        for (int i = 0; i < N; i++) pk[i*AW +: AW] = cur_arg[i];
        bus.arg_vld = vld;
        bus.arg     = pk;
        inj         = inj_i;
        #1;
        gv = 1'b0;
        gi = 0;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (mptr + k) % N;
            if (!gv && vld[j]) begin
                gv = 1'b1;
                gi = j;
            end
        end
        exp_rdy = gv ? (N'(1) << gi) : '0;
        check("arg_rdy", bus.arg_rdy, exp_rdy);
        check("x_vld", bus.x_vld, exp_xv);
        if (exp_xv) check("x", bus.x, exp_x);
        if (q.size() > 0 && q[0].due == cyc) begin
            check("res_vld", bus.res_vld, N'(1) << q[0].idx);
            check("res", bus.res, q[0].val);
            void'(q.pop_front());
        end else begin
            check("res_vld_idle", bus.res_vld, 0);
        end
        check("err", bus.err, merr);
        if (inj_i) merr = 1'b1;
        if (gv) begin
            q.push_back('{gi, isqrt_f(cur_arg[gi]), cyc + LAT + 1});
            mptr        = (gi + 1) % N;
            exp_xv      = 1'b1;
            exp_x       = cur_arg[gi];
            mcnt[gi]    = (mcnt[gi] + 1) % 65536;
            cur_arg[gi] = rnd_arg();
        end else begin
            exp_xv = 1'b0;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        bus.arg_vld = '1;
        inj         = 1'b0;
        rst         = 1'b1;
        #1;
        check("rst_arg_rdy", bus.arg_rdy, 0);
        check("rst_res_vld", bus.res_vld, 0);
        check("rst_x_vld", bus.x_vld, 0);
        check("rst_x", bus.x, 0);
        check("rst_err", bus.err, 0);
`ifdef ISQRT_SHARER_STATS_EN
        check("rst_grant_cnt", grant_cnt, 0);
`endif
        @(negedge clk);
        rst         = 1'b0;
        bus.arg_vld = '0;
        q.delete();
        mptr   = 0;
        exp_xv = 1'b0;
        exp_x  = '0;
        merr   = 1'b0;
        for (int i = 0; i < N; i++) mcnt[i] = 0;
        cyc++;
    endtask

    task automatic idle(input int n);
        logic g;
        int   i;
        for (int c = 0; c < n; c++) cycle('0, 1'b0, g, i);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic         gv;
        int           gi;
        logic         p3;
        int           w3, n3;
        logic [N-1:0] pend;
        int           waitc [N];

        total = 0; bad = 0; cyc = 0; mptr = 0;
        exp_xv = 1'b0; exp_x = '0; merr = 1'b0;
        rst = 1'b1; inj = 1'b0;
        bus.arg_vld = '0; bus.arg = '0;
        for (int i = 0; i < N; i++) begin
            cur_arg[i] = rnd_arg();
            mcnt[i]    = 0;
        end
        @(negedge clk);
        do_reset();

        // Single request from requester 2: sqrt(144)=12 after LAT+1 cycles.
        cur_arg[2] = 32'd144;
        cycle(4'b0100, 1'b0, gv, gi);
        check("single_gv", gv, 1);
        check("single_gi", gi, 2);
        idle(LAT + 3);

        // All requesters hold valid from ptr=0: strict rotation.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cycle('1, 1'b0, gv, gi);
            check("rr_order", gi, i % N);
        end
        idle(LAT + 3);

        // Req 1 continuous, req 3 reasserting every other cycle.
        p3 = 1'b0; w3 = 0; n3 = 0;
        for (int c = 0; c < 20; c++) begin
            if (!p3 && (c % 2 == 0)) begin
                p3 = 1'b1;
                w3 = 0;
            end
            if (p3) w3++;
            cycle({p3, 1'b0, 1'b1, 1'b0}, 1'b0, gv, gi);
            if (gv && gi == 3) begin
                check("req3_wait_le2", w3 <= 2, 1);
                p3 = 1'b0;
                n3++;
            end
        end
        check("req3_granted", n3 > 0, 1);
        idle(LAT + 3);

        // Reset with three requests in flight: nothing comes back, ptr restarts at 0.
        for (int i = 0; i < 3; i++) cycle('1, 1'b0, gv, gi);
        do_reset();
        idle(LAT + 3);
        cycle(4'b1010, 1'b0, gv, gi);
        check("ptr_after_rst", gi, 1);
        cycle('1, 1'b0, gv, gi);
        check("ptr_after_grant", gi, 2);
        idle(LAT + 3);

        // Spurious y_vld with an empty tag pipe: err goes sticky.
        cycle('0, 1'b1, gv, gi);
        idle(4);
        check("err_sticky", bus.err, 1);
        do_reset();

        // Random traffic; pending requests hold a stable arg until granted.
        pend = '0;
        for (int i = 0; i < N; i++) waitc[i] = 0;
        for (int c = 0; c < 2500; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 99) < 45) begin
                    pend[i]  = 1'b1;
                    waitc[i] = 0;
                end else if (pend[i] && $urandom_range(0, 99) < 3) begin
                    pend[i] = 1'b0;
                end
                if (pend[i]) waitc[i]++;
            end
            cycle(pend, 1'b0, gv, gi);
            if (gv) begin
                check("starvation_bound", waitc[gi] <= N, 1);
                pend[gi] = 1'b0;
            end
        end
        idle(LAT + 3);
        check("drained", q.size(), 0);

`ifdef ISQRT_SHARER_STATS_EN
        for (int i = 0; i < N; i++) check("grant_cnt", grant_cnt[i*16 +: 16], mcnt[i]);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/isqrt_rr_sharer.md
ISQRT_RR_SHARER -- requirements
Module: isqrt_rr_sharer

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing one pipelined isqrt unit, legal range 2..16.
REQ-002 Parameter ARG_W, default 32, argument width.
REQ-003 Parameter RES_W, default 16, result width, equal to ARG_W/2.
REQ-004 Parameter ISQRT_LAT, default 4, fixed isqrt latency in cycles from x_vld to y_vld, legal range >= 1.
REQ-005 clk  input  1  single clock, all state on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset, shared with the isqrt unit.
REQ-007 arg_vld  input  N_REQ  per-requester request valid.
REQ-008 arg  input  N_REQ*ARG_W  per-requester argument; requester i occupies bits [i*ARG_W +: ARG_W].
REQ-009 arg_rdy  output  N_REQ  one-hot-or-zero grant; the request is accepted when arg_vld[i] & arg_rdy[i].
REQ-010 x_vld  output  1  isqrt input valid, registered.
REQ-011 x  output  ARG_W  isqrt argument, registered.
REQ-012 y_vld  input  1  isqrt result valid.
REQ-013 y  input  RES_W  isqrt result.
REQ-014 res_vld  output  N_REQ  one-hot-or-zero result valid, routed to the originating requester.
REQ-015 res  output  RES_W  shared result bus, equal to y.
REQ-016 err  output  1  sticky protocol error flag.

Function
REQ-017 Round-robin pointer ptr (0..N_REQ-1); grant the first asserted arg_vld index searching ptr, ptr+1, ... with wrap-around modulo N_REQ.
REQ-018 arg_rdy is combinational from arg_vld and ptr; at most one bit set per cycle; all zero when arg_vld is zero.
REQ-019 After a grant to index g, ptr becomes (g+1) mod N_REQ on the next edge; with no grant, ptr holds.
REQ-020 On the edge of a grant, x_vld<=1 and x<=arg of g; otherwise x_vld<=0 and x holds its value.
REQ-021 The tag pipeline is ISQRT_LAT stages of {valid, index}, loaded from {x_vld, index of the granted requester latched with x}; it shifts every cycle with no stall.
REQ-022 res_vld[t]=y_vld & tag_out.valid for t=tag_out.index; all other bits are 0; combinational.
REQ-023 Total latency: acceptance edge to res_vld is ISQRT_LAT+1 cycles; throughput is one request per cycle.
REQ-024 Result order equals grant order; there is no reordering and no dropping.
REQ-025 err sets on the next edge when y_vld != tag_out.valid, and holds until reset.
REQ-026 A requester holding arg_vld with a stable arg receives a grant within N_REQ cycles, so no requester starves.
REQ-027 A requester may deassert arg_vld before a grant without side effect; a new request may be accepted in the same cycle that a result is delivered to that requester.

Reset
REQ-028 While rst=1: ptr=0, x_vld=0, x=0, all tag valids=0, err=0, and counters (if present)=0; arg_rdy and res_vld are forced 0.
REQ-029 Reset mid-operation discards all in-flight tags and sends no res_vld for them; the isqrt unit is reset on the same rst.

Configuration
REQ-030 Macro ISQRT_SHARER_STATS_EN defined: add output grant_cnt N_REQ*16, where counter i increments on each acceptance for requester i, wraps at 16'hFFFF to 0, and resets to 0.
REQ-031 Macro ISQRT_SHARER_STATS_EN undefined: the grant_cnt port and counters are absent; all other behaviour is identical.

Verification
REQ-032 ISQRT_LAT=4, only req 2 with arg=144 for 1 cycle -> x_vld with x=144 on the next cycle; res_vld=4'b0100, res=12 five cycles after acceptance.
REQ-033 All 4 requesters hold arg_vld for 8 cycles with ptr=0 -> grants 0,1,2,3,0,1,2,3, and results return in that order with correct sqrt.
REQ-034 req 1 holds arg_vld continuously and req 3 pulses every other cycle -> req 3 is granted within 2 cycles of each assertion.
REQ-035 Assert rst for 1 cycle with 3 requests in flight -> no res_vld afterwards for them, err stays 0, and ptr=0.
REQ-036 Inject y_vld=1 with an empty tag pipe -> err=1 next cycle and it stays 1 until rst.
REQ-037 With ISQRT_SHARER_STATS_EN, 70000 grants to req 0 -> grant_cnt[15:0]=70000-65536=4464.
